ccff_chain_loader: RTL and testbench



---
 rtl/ccff_chain_loader_if.sv | 27 ++
 rtl/ccff_chain_loader.sv | 198 +++++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccff_chain_loader_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ccff_chain_loader_if
// Brief    : valid/ready configuration-word stream into the CCFF chain loader
// Revision : 1.0
// ============================================================================
interface ccff_chain_loader_if #(
   parameter int WORD_W = 8
);
   logic              cfg_valid;
   logic              cfg_ready;
   logic [WORD_W-1:0] cfg_data;

   modport master (
      output cfg_valid,
      output cfg_data,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_data,
      output cfg_ready
   );
endinterface
`default_nettype wire

// File: rtl/ccff_chain_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ccff_chain_loader
// Brief    : serialises config words LSB-first into a CCFF chain, counting
//            exactly CHAIN_LEN shift pulses; CCFF_PARITY_CHECK_EN adds a
//            recirculating parity verify pass that drives error.
// Revision : 1.0
// ============================================================================
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 64,
   parameter int WORD_W    = 8,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   ccff_chain_loader_if.slave cfg,
   output logic               ccff_head,
   output logic               ccff_shift_en,
   input  logic               ccff_tail,
   output logic               busy,
   output logic               done,
   output logic               error
);

   localparam int               REM_W    = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

`ifdef CCFF_PARITY_CHECK_EN
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_VERIFY = 2'd2,
      S_DONE   = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_DONE   = 2'd3
   } state_t;
`endif

   state_t            state, state_nxt;
   logic [WORD_W-1:0] word_buf, word_buf_nxt;
   logic [REM_W-1:0]  rem, rem_nxt;
   logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
   logic              head_nxt;
   logic              shift_nxt;
   logic              busy_nxt;
   logic              done_nxt;

`ifdef CCFF_PARITY_CHECK_EN
   logic              error_nxt;
   logic              load_par, load_par_nxt;
   logic              tail_par, tail_par_nxt;
   logic              phase, phase_nxt;
`else
   logic              unused_tail;

   assign unused_tail = ccff_tail;
   assign error       = 1'b0;
`endif

   // Ready depends on registered state only, never on cfg_valid.
   assign cfg.cfg_ready = (state == S_LOAD) && (rem == '0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= S_IDLE;
         word_buf      <= '0;
         rem           <= '0;
         bit_cnt       <= '0;
         ccff_head     <= 1'b0;
         ccff_shift_en <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
`ifdef CCFF_PARITY_CHECK_EN
         error         <= 1'b0;
         load_par      <= 1'b0;
         tail_par      <= 1'b0;
         phase         <= 1'b0;
`endif
      end else begin
         state         <= state_nxt;
         word_buf      <= word_buf_nxt;
         rem           <= rem_nxt;
         bit_cnt       <= bit_cnt_nxt;
         ccff_head     <= head_nxt;
         ccff_shift_en <= shift_nxt;
         busy          <= busy_nxt;
         done          <= done_nxt;
`ifdef CCFF_PARITY_CHECK_EN
         error         <= error_nxt;
         load_par      <= load_par_nxt;
         tail_par      <= tail_par_nxt;
         phase         <= phase_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt    = state;
      word_buf_nxt = word_buf;
      rem_nxt      = rem;
      bit_cnt_nxt  = bit_cnt;
      head_nxt     = ccff_head;
      shift_nxt    = 1'b0;
      busy_nxt     = busy;
      done_nxt     = done;
`ifdef CCFF_PARITY_CHECK_EN
      error_nxt    = error;
      load_par_nxt = load_par;
      tail_par_nxt = tail_par;
      phase_nxt    = phase;
`endif

      case (state)
         S_IDLE, S_DONE: begin
            busy_nxt = 1'b0;
            if (state == S_DONE) begin
               done_nxt  = 1'b1;
`ifdef CCFF_PARITY_CHECK_EN
               error_nxt = load_par ^ tail_par;
`endif
            end
            if (start) begin
               state_nxt   = S_LOAD;
               bit_cnt_nxt = '0;
               rem_nxt     = '0;
               busy_nxt    = 1'b1;
               done_nxt    = 1'b0;
`ifdef CCFF_PARITY_CHECK_EN
               error_nxt    = 1'b0;
               load_par_nxt = 1'b0;
               tail_par_nxt = 1'b0;
               phase_nxt    = 1'b0;
`endif
            end
         end

         S_LOAD: begin
            busy_nxt = 1'b1;
            if (rem != '0) begin
               shift_nxt    = 1'b1;
               head_nxt     = word_buf[0];
               word_buf_nxt = word_buf >> 1;
               rem_nxt      = rem - REM_W'(1);
               bit_cnt_nxt  = bit_cnt + CNT_W'(1);
`ifdef CCFF_PARITY_CHECK_EN
               load_par_nxt = load_par ^ word_buf[0];
`endif
               // Last chain bit: drop whatever is left of the word.
               if (bit_cnt == LAST_BIT) begin
                  rem_nxt = '0;
`ifdef CCFF_PARITY_CHECK_EN
                  state_nxt   = S_VERIFY;
                  bit_cnt_nxt = '0;
                  phase_nxt   = 1'b0;
`else
                  state_nxt   = S_DONE;
`endif
               end
            end else if (cfg.cfg_valid) begin
               word_buf_nxt = cfg.cfg_data;
               rem_nxt      = REM_W'(WORD_W);
            end
         end

`ifdef CCFF_PARITY_CHECK_EN
         // Pulses alternate with idle cycles so ccff_tail is always sampled
         // from a settled chain: the registered head lags the sample by one.
         S_VERIFY: begin
            busy_nxt = 1'b1;
            if (!phase) begin
               phase_nxt = 1'b1;
            end else begin
               phase_nxt    = 1'b0;
               shift_nxt    = 1'b1;
               head_nxt     = ccff_tail;
               tail_par_nxt = tail_par ^ ccff_tail;
               bit_cnt_nxt  = bit_cnt + CNT_W'(1);
               if (bit_cnt == LAST_BIT) begin
                  state_nxt = S_DONE;
               end
            end
         end
`endif

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ccff_chain_loader
// Brief    : scoreboard bench for ccff_chain_loader with a shift-register chain
// Revision : 1.0
// ============================================================================
module tb_ccff_chain_loader;

   localparam int CHAIN_LEN = 20;
   localparam int WORD_W    = 8;
`ifdef CCFF_PARITY_CHECK_EN
   localparam int PULSES = 2 * CHAIN_LEN;
`else
   localparam int PULSES = CHAIN_LEN;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic ccff_head, ccff_shift_en, ccff_tail, busy, done, error;

   ccff_chain_loader_if #(.WORD_W(WORD_W)) cfg_if ();

   ccff_chain_loader #(
      .CHAIN_LEN (CHAIN_LEN),
      .WORD_W    (WORD_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .cfg           (cfg_if),
      .ccff_head     (ccff_head),
      .ccff_shift_en (ccff_shift_en),
      .ccff_tail     (ccff_tail),
      .busy          (busy),
      .done          (done),
      .error         (error)
   );

   always #5 clk = ~clk;

   // Chain model; a pending flip corrupts bit 0 once, on a non-shift edge.
   logic [CHAIN_LEN-1:0] chain        = '0;
   logic                 flip_pending = 1'b0;
   logic                 flip_applied = 1'b0;

   always @(posedge clk) begin
      if (ccff_shift_en) begin
         chain <= {chain[CHAIN_LEN-2:0], ccff_head};
      end else if (flip_pending && !flip_applied) begin
         chain        <= chain ^ {{(CHAIN_LEN-1){1'b0}}, 1'b1};
         flip_applied <= 1'b1;
      end
      if (!flip_pending) flip_applied <= 1'b0;
   end

   assign ccff_tail = chain[CHAIN_LEN-1];

   int                   n_checks = 0;
   int                   n_fail   = 0;
   logic                 exp_q[$];
   logic [WORD_W-1:0]    words[3];
   logic [CHAIN_LEN-1:0] exp_img;
   int                   res_hs, res_pulses, res_gap_pulses, res_done_lag;
   bit                   res_aborted, res_after_start;

   task automatic drive_load(input int gap, input int restart_bit,
                             input int reset_bit, input int flip_bit);
      int   widx      = 0;
      int   gap_seen  = 0;
      int   last_cyc  = 0;
      int   pushed    = 0;
      bit   restarted = 1'b0;
      bit   finished  = 1'b0;
      bit   in_gap;
      logic e;
      res_hs = 0; res_pulses = 0; res_gap_pulses = 0; res_done_lag = -1;
      res_aborted = 1'b0; res_after_start = 1'b0;
      exp_q.delete();
      exp_img = '0;
      cfg_if.cfg_valid = 1'b0;
      @(negedge clk);
      start = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (cyc == 0) res_after_start = (busy === 1'b1) && (done === 1'b0);
         if (ccff_shift_en === 1'b1) begin
            res_pulses++;
            last_cyc = cyc;
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               n_checks++;
               if (ccff_head !== e) begin
                  n_fail++;
                  $display("FAIL head_bit%0d: got %b expected %b", res_pulses - 1, ccff_head, e);
               end
            end
         end
         if (done === 1'b1 && busy === 1'b0) begin
            res_done_lag = cyc - last_cyc;
            finished = 1'b1;
            break;
         end
         if (reset_bit >= 0 && res_pulses == reset_bit) begin
            reset = 1'b0;
            cfg_if.cfg_valid = 1'b0;
            res_aborted = 1'b1;
            break;
         end
         if (restart_bit >= 0 && !restarted && res_pulses == restart_bit) begin
            start = 1'b1;
            restarted = 1'b1;
         end
         if (flip_bit >= 0 && res_pulses == flip_bit) flip_pending = 1'b1;
         in_gap = (widx == 1) && (gap_seen < gap);
         cfg_if.cfg_valid = (widx < 3) && !in_gap;
         if (widx < 3) cfg_if.cfg_data = words[widx];
         else          cfg_if.cfg_data = '0;
         if (in_gap && cfg_if.cfg_ready === 1'b1) begin
            gap_seen++;
            if (gap_seen >= 2 && ccff_shift_en === 1'b1) res_gap_pulses++;
         end
         if (cfg_if.cfg_valid === 1'b1 && cfg_if.cfg_ready === 1'b1) begin
            res_hs++;
            for (int b = 0; b < WORD_W; b++) begin
               if (pushed < CHAIN_LEN) begin
                  exp_q.push_back(words[widx][b]);
                  exp_img[CHAIN_LEN-1-pushed] = words[widx][b];
                  pushed++;
               end
            end
            widx++;
         end
      end
      cfg_if.cfg_valid = 1'b0;
      if (finished) begin
         repeat (3) begin
            @(negedge clk);
            if (ccff_shift_en === 1'b1) res_pulses++;
         end
      end else if (!res_aborted) begin
         n_checks++;
         n_fail++;
         $display("FAIL load_timeout: got done=%b busy=%b expected done=1 busy=0", done, busy);
      end
      flip_pending = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_data  = '0;
      repeat (3) @(negedge clk);
      n_checks += 6;
      if (cfg_if.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", cfg_if.cfg_ready); end
      if (ccff_head !== 1'b0)        begin n_fail++; $display("FAIL rst_head: got %b expected 0", ccff_head); end
      if (ccff_shift_en !== 1'b0)    begin n_fail++; $display("FAIL rst_shift: got %b expected 0", ccff_shift_en); end
      if (busy !== 1'b0)             begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
      if (done !== 1'b0)             begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
      if (error !== 1'b0)            begin n_fail++; $display("FAIL rst_error: got %b expected 0", error); end
      reset = 1'b1;
      cfg_if.cfg_valid = 1'b1;
      repeat (2) @(negedge clk);
      n_checks += 2;
      if (cfg_if.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %b expected 0", cfg_if.cfg_ready); end
      if (busy !== 1'b0)             begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
      cfg_if.cfg_valid = 1'b0;
   endtask

   task automatic test_basic_load();
      words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
      drive_load(0, -1, -1, -1);
      n_checks += 7;
      if (res_pulses !== PULSES) begin n_fail++; $display("FAIL basic_pulses: got %0d expected %0d", res_pulses, PULSES); end
      if (res_hs !== 3)          begin n_fail++; $display("FAIL basic_handshakes: got %0d expected 3", res_hs); end
      if (res_done_lag !== 1)    begin n_fail++; $display("FAIL basic_done_lag: got %0d expected 1", res_done_lag); end
      if (exp_q.size() !== 0)    begin n_fail++; $display("FAIL basic_bits_left: got %0d expected 0", exp_q.size()); end
      if (chain !== exp_img)     begin n_fail++; $display("FAIL basic_chain: got %h expected %h", chain, exp_img); end
      if (error !== 1'b0)        begin n_fail++; $display("FAIL basic_error: got %b expected 0", error); end
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL basic_status: got done=%b busy=%b expected done=1 busy=0", done, busy);
      end
   endtask

   task automatic test_valid_gap();
      words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
      drive_load(5, -1, -1, -1);
      n_checks += 5;
      if (res_pulses !== PULSES)  begin n_fail++; $display("FAIL gap_pulses: got %0d expected %0d", res_pulses, PULSES); end
      if (res_gap_pulses !== 0)   begin n_fail++; $display("FAIL gap_shift_en: got %0d pulses expected 0", res_gap_pulses); end
      if (res_hs !== 3)           begin n_fail++; $display("FAIL gap_handshakes: got %0d expected 3", res_hs); end
      if (exp_q.size() !== 0)     begin n_fail++; $display("FAIL gap_bits_left: got %0d expected 0", exp_q.size()); end
      if (chain !== exp_img)      begin n_fail++; $display("FAIL gap_chain: got %h expected %h", chain, exp_img); end
   endtask

   task automatic test_restart_ignored();
      words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
      drive_load(0, 7, -1, -1);
      n_checks += 3;
      if (res_pulses !== PULSES) begin n_fail++; $display("FAIL restart_pulses: got %0d expected %0d", res_pulses, PULSES); end
      if (chain !== exp_img)     begin n_fail++; $display("FAIL restart_chain: got %h expected %h", chain, exp_img); end
      if (done !== 1'b1)         begin n_fail++; $display("FAIL restart_done: got %b expected 1", done); end
   endtask

   task automatic test_reset_midload();
      words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
      drive_load(0, -1, 10, -1);
      n_checks++;
      if (!res_aborted) begin n_fail++; $display("FAIL midrst_reached: got %b expected 1", res_aborted); end
      @(negedge clk);
      n_checks += 6;
      if (cfg_if.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", cfg_if.cfg_ready); end
      if (ccff_head !== 1'b0)        begin n_fail++; $display("FAIL midrst_head: got %b expected 0", ccff_head); end
      if (ccff_shift_en !== 1'b0)    begin n_fail++; $display("FAIL midrst_shift: got %b expected 0", ccff_shift_en); end
      if (busy !== 1'b0)             begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      if (done !== 1'b0)             begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done); end
      if (error !== 1'b0)            begin n_fail++; $display("FAIL midrst_error: got %b expected 0", error); end
      reset = 1'b1;
      @(negedge clk);
      drive_load(0, -1, -1, -1);
      n_checks += 3;
      if (res_pulses !== PULSES) begin n_fail++; $display("FAIL reload_pulses: got %0d expected %0d", res_pulses, PULSES); end
      if (exp_q.size() !== 0)    begin n_fail++; $display("FAIL reload_bits_left: got %0d expected 0", exp_q.size()); end
      if (chain !== exp_img)     begin n_fail++; $display("FAIL reload_chain: got %h expected %h", chain, exp_img); end
   endtask

   task automatic test_back_to_back();
      n_checks++;
      if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_pre_done: got %b expected 1", done); end
      words[0] = 8'h00; words[1] = 8'h00; words[2] = 8'h00;
      drive_load(0, -1, -1, -1);
      n_checks += 4;
      if (!res_after_start)      begin n_fail++; $display("FAIL b2b_done_clear: got %b expected 1", res_after_start); end
      if (res_pulses !== PULSES) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected %0d", res_pulses, PULSES); end
      if (chain !== '0)          begin n_fail++; $display("FAIL b2b_chain: got %h expected 0", chain); end
      if (done !== 1'b1)         begin n_fail++; $display("FAIL b2b_done: got %b expected 1", done); end
   endtask

`ifdef CCFF_PARITY_CHECK_EN
   task automatic test_parity_verify();
      words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
      drive_load(0, -1, -1, -1);
      n_checks += 4;
      if (res_pulses !== 2 * CHAIN_LEN) begin n_fail++; $display("FAIL par_pulses: got %0d expected %0d", res_pulses, 2 * CHAIN_LEN); end
      if (error !== 1'b0)               begin n_fail++; $display("FAIL par_clean_error: got %b expected 0", error); end
      if (done !== 1'b1)                begin n_fail++; $display("FAIL par_clean_done: got %b expected 1", done); end
      if (chain !== exp_img)            begin n_fail++; $display("FAIL par_chain_kept: got %h expected %h", chain, exp_img); end
      drive_load(0, -1, -1, CHAIN_LEN);
      n_checks += 2;
      if (error !== 1'b1) begin n_fail++; $display("FAIL par_fault_error: got %b expected 1", error); end
      if (done !== 1'b1)  begin n_fail++; $display("FAIL par_fault_done: got %b expected 1", done); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_load();
      test_valid_gap();
      test_restart_ignored();
      test_reset_midload();
      test_back_to_back();
`ifdef CCFF_PARITY_CHECK_EN
      test_parity_verify();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
